// File: rtl/trivium_stream_core.sv
// trivium_stream_core -- word-parallel Trivium stream-cipher core.
// Loads an 80-bit key and 80-bit IV as a 160-bit stream of W-bit words,
// warms the 288-bit cipher state up, then either XORs input words with the
// keystream (mode 0) or emits raw keystream words (mode 1).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   init_i, mode_i        start/restart a session, mode sampled with init_i
//   end_i                 end the session (meaningful in PROC only)
//   dat_i/dat_vld_i/dat_rdy_o   input word handshake (key/IV or data)
//   dat_o/dat_vld_o/dat_rdy_i   registered output word handshake
//   busy_o                high in LOAD, WARMUP and DRAIN
module trivium_stream_core #(
  parameter int unsigned W             = 1,
  parameter int unsigned WARMUP_ROUNDS = 1152
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         init_i,
  input  logic         mode_i,
  input  logic         end_i,
  input  logic [W-1:0] dat_i,
  input  logic         dat_vld_i,
  output logic         dat_rdy_o,
  output logic [W-1:0] dat_o,
  output logic         dat_vld_o,
  input  logic         dat_rdy_i,
  output logic         busy_o
);

  localparam int unsigned NWORDS = 160 / W;
  localparam int unsigned NW     = WARMUP_ROUNDS / W;
  localparam int unsigned WCW    = $clog2(NWORDS);
  localparam int unsigned UCW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, PROC, DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 mode_q;
  logic [WCW-1:0]       wcnt_q;
  logic [UCW-1:0]       ucnt_q;
  logic [287:0]         st_q;
  logic [287:0]         st_step;
  // Only the first NWORDS-1 words are stored; the last word is taken
  // straight from dat_i when the cipher state is loaded.
  logic [159-W:0]       kiv_q;
  logic [159:0]         kiv_d;
  logic [W-1:0]         ks;
  logic                 out_free, in_xfer, out_load, vld_d;
  logic                 load_last, warm_last;

  // W cipher steps; bit k of st (0-based) holds Trivium state bit s(k+1).
  always_comb begin
    logic [287:0] s;
    logic         t1, t2, t3;
    s  = st_q;
    ks = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      t1    = s[65] ^ s[92];
      t2    = s[161] ^ s[176];
      t3    = s[242] ^ s[287];
      ks[i] = t1 ^ t2 ^ t3;
      t1    = t1 ^ (s[90] & s[91]) ^ s[170];
      t2    = t2 ^ (s[174] & s[175]) ^ s[263];
      t3    = t3 ^ (s[285] & s[286]) ^ s[68];
      s     = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    st_step = s;
  end

  always_comb begin
    kiv_d     = {dat_i, kiv_q};
    out_free  = !dat_vld_o || dat_rdy_i;
    dat_rdy_o = (state_q == LOAD) || (state_q == PROC && !mode_q && out_free);
    busy_o    = (state_q == LOAD) || (state_q == WARMUP) || (state_q == DRAIN);
    in_xfer   = dat_vld_i && dat_rdy_o;
    out_load  = (state_q == PROC) && (mode_q ? out_free : in_xfer);
    vld_d     = out_load || (dat_vld_o && !dat_rdy_i);
    load_last = (state_q == LOAD) && in_xfer && (wcnt_q == WCW'(NWORDS - 1));
    warm_last = (ucnt_q == UCW'(NW - 1));
  end

  always_comb begin
    state_d = state_q;
    if (init_i) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (load_last) state_d = WARMUP;
        WARMUP:  if (warm_last) state_d = PROC;
        // A transfer in the end_i cycle still completes; leave via DRAIN
        // only if a word will still be waiting in dat_o afterwards.
        PROC:    if (end_i) state_d = vld_d ? DRAIN : IDLE;
        DRAIN:   if (!vld_d) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= 1'b0;
      wcnt_q    <= '0;
      ucnt_q    <= '0;
      st_q      <= '0;
      kiv_q     <= '0;
      dat_o     <= '0;
      dat_vld_o <= 1'b0;
    end else if (init_i) begin
      mode_q    <= mode_i;
      wcnt_q    <= '0;
      ucnt_q    <= '0;
      dat_vld_o <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_xfer) begin
            if (load_last) begin
              wcnt_q <= '0;
              st_q   <= {3'b111, 112'b0, kiv_d[159:80], 13'b0, kiv_d[79:0]};
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
              kiv_q  <= kiv_d[159:W];
            end
          end
        end
        WARMUP: begin
          st_q   <= st_step;
          ucnt_q <= warm_last ? '0 : ucnt_q + 1'b1;
        end
        PROC, DRAIN: begin
          if (out_load) begin
            st_q      <= st_step;
            dat_o     <= mode_q ? ks : (dat_i ^ ks);
            dat_vld_o <= 1'b1;
          end else if (dat_rdy_i) begin
            dat_vld_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
